// File: rtl/nes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nes_pkg
// Description : Shared definitions for the NES serial pad protocol.
//               - Button bit positions within the 8-bit button word.
//               - Controller-device state encoding.
//               - Frame length and index width.
// Revision    : 1.0 - initial release
// ============================================================================
package nes_pkg;

  // Button positions, 1 = pressed. A goes out first, Right goes out last.
  localparam int BTN_A      = 7;
  localparam int BTN_B      = 6;
  localparam int BTN_SELECT = 5;
  localparam int BTN_START  = 4;
  localparam int BTN_UP     = 3;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_RIGHT  = 0;

  localparam int NES_BITS  = 8;
  localparam int NES_IDX_W = $clog2(NES_BITS);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_SHIFT     = 2'd2,
    ST_EXHAUSTED = 2'd3
  } dev_state_e;

endpackage : nes_pkg
`default_nettype wire

// File: rtl/nes_sync.sv
`default_nettype none
// ============================================================================
// Module      : nes_sync
// Description : N-stage flop synchronizer for a single asynchronous line.
//               The reset value is a parameter so that each line resets to
//               its own idle level.
// Ports       : clk   - system clock
//               i_rst - asynchronous active-high reset
//               i_d   - asynchronous input
//               o_q   - synchronized output
// Revision    : 1.0 - initial release
// ============================================================================
module nes_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], i_d};
    end
  end

  assign o_q = sync_q[STAGES-1];

endmodule : nes_sync
`default_nettype wire

// File: rtl/nes_controller_device.sv
`default_nettype none
// ============================================================================
// Module      : nes_controller_device
// Description : Controller side of the NES serial pad protocol. Samples the
//               console latch/clock lines, parallel-loads the button word
//               while latch is high, and shifts it out active-low, one bit
//               per rising edge of the console clock.
// Ports       : clk             - system clock
//               i_rst           - asynchronous active-high reset
//               i_buttons       - button word, 1 = pressed, [7]=A .. [0]=Right
//               i_console_latch - latch from console (async, idles low)
//               i_console_clock - clock from console (async, idles high)
//               o_console_data  - registered serial data, low = pressed
//               o_latched       - pulse when the snapshot becomes final
//               o_read_done     - pulse when the Right bit starts being driven
// Revision    : 1.0 - initial release
// ============================================================================
module nes_controller_device
  import nes_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       i_rst,
  input  logic [7:0] i_buttons,
  input  logic       i_console_latch,
  input  logic       i_console_clock,
  output logic       o_console_data,
  output logic       o_latched,
  output logic       o_read_done
);

  localparam logic [NES_IDX_W-1:0] IDX_LAST   = NES_IDX_W'(NES_BITS - 1);
  localparam logic [NES_IDX_W-1:0] IDX_PENULT = NES_IDX_W'(NES_BITS - 2);

  logic latch_sync;
  logic clock_sync;

  nes_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_latch (
    .clk   (clk),
    .i_rst (i_rst),
    .i_d   (i_console_latch),
    .o_q   (latch_sync)
  );

  nes_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_clock (
    .clk   (clk),
    .i_rst (i_rst),
    .i_d   (i_console_clock),
    .o_q   (clock_sync)
  );

  logic                 latch_prev_q;
  logic                 clock_prev_q;
  dev_state_e           state_q;
  logic [NES_BITS-1:0]  shift_q;
  logic [NES_IDX_W-1:0] idx_q;
  logic                 latched_evt_q;
  logic                 done_evt_q;
  logic                 data_q;
  logic                 latched_q;
  logic                 read_done_q;

  logic latch_fall;
  logic clock_rise;

  assign latch_fall = latch_prev_q & ~latch_sync;
  assign clock_rise = clock_sync & ~clock_prev_q;

  // Two register stages after the synchronizer: the first updates the
  // protocol state, the second drives the pins from that state. The event
  // flags ride along so the pulses line up with the data update.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      latch_prev_q  <= 1'b0;
      clock_prev_q  <= 1'b1;
      state_q       <= ST_IDLE;
      shift_q       <= '0;
      idx_q         <= '0;
      latched_evt_q <= 1'b0;
      done_evt_q    <= 1'b0;
      data_q        <= 1'b1;
      latched_q     <= 1'b0;
      read_done_q   <= 1'b0;
    end else begin
      latch_prev_q  <= latch_sync;
      clock_prev_q  <= clock_sync;
      latched_evt_q <= 1'b0;
      done_evt_q    <= 1'b0;

      // Latch high dominates everything, including an in-progress frame.
      if (latch_sync) begin
        state_q <= ST_LOAD;
        shift_q <= i_buttons;
        idx_q   <= '0;
      end else begin
        unique case (state_q)
          ST_LOAD: begin
            if (latch_fall) begin
              state_q       <= ST_SHIFT;
              idx_q         <= '0;
              latched_evt_q <= 1'b1;
            end
          end
          ST_SHIFT: begin
            if (clock_rise) begin
              shift_q <= {shift_q[NES_BITS-2:0], 1'b0};
              if (idx_q == IDX_LAST) begin
                state_q <= ST_EXHAUSTED;
              end else begin
                idx_q      <= idx_q + 1'b1;
                done_evt_q <= (idx_q == IDX_PENULT);
              end
            end
          end
          default: ;
        endcase
      end

      latched_q   <= latched_evt_q;
      read_done_q <= done_evt_q;
      unique case (state_q)
        ST_IDLE:      data_q <= 1'b1;
        ST_EXHAUSTED: data_q <= 1'b0;
        default:      data_q <= ~shift_q[BTN_A];
      endcase
    end
  end

  assign o_console_data = data_q;
  assign o_latched      = latched_q;
  assign o_read_done    = read_done_q;

endmodule : nes_controller_device
`default_nettype wire

// File: tb/tb_nes_controller_device.sv
`default_nettype none
// ============================================================================
// Module      : tb_nes_controller_device
// Description : Scoreboard bench for nes_controller_device. Stimulus pushes
//               expected events; a monitor pops and compares whenever the
//               DUT pulses o_latched/o_read_done, a data sample is requested,
//               or the bench host reader reports a word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nes_controller_device;

  localparam int CPP = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] buttons;
  logic       latch;
  logic       cclk;
  logic       data;
  logic       latched;
  logic       read_done;

  always #5 clk = ~clk;

  nes_controller_device #(.SYNC_STAGES(2)) dut (
    .clk             (clk),
    .i_rst           (rst),
    .i_buttons       (buttons),
    .i_console_latch (latch),
    .i_console_clock (cclk),
    .o_console_data  (data),
    .o_latched       (latched),
    .o_read_done     (read_done)
  );

  typedef enum logic [1:0] {EV_LATCH, EV_DONE, EV_DATA, EV_HOST} ev_e;
  typedef struct packed {
    ev_e        kind;
    logic [7:0] val;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic       sample_req   = 1'b0;
  logic       host_valid   = 1'b0;
  logic [7:0] host_buttons = 8'h00;

  function automatic void check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic void push(input ev_e k, input logic [7:0] v);
    exp_t e;
    e.kind = k;
    e.val  = v;
    sb_q.push_back(e);
  endfunction

  function automatic void sb_pop(input ev_e kind, input logic [7:0] act, input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: unexpected event with value %0h, expected no event", name, act);
      return;
    end
    e = sb_q.pop_front();
    if (e.kind != kind) begin
      n_checks++;
      $display("FAIL %s: got event kind %0d expected kind %0d", name, kind, e.kind);
    end else begin
      check(name, act, e.val);
    end
  endfunction

  // Monitor: events in the same cycle are consumed in a fixed order.
  always @(negedge clk) begin
    if (latched)    sb_pop(EV_LATCH, {7'd0, data}, "latched");
    if (read_done)  sb_pop(EV_DONE,  {7'd0, data}, "read_done");
    if (sample_req) sb_pop(EV_DATA,  {7'd0, data}, "data");
    if (host_valid) sb_pop(EV_HOST,  host_buttons, "host_read");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic exp);
    push(EV_DATA, {7'd0, exp});
    sample_req = 1'b1;
    tick(1);
    sample_req = 1'b0;
  endtask

  task automatic latch_frame(input logic [7:0] b, input int hi);
    buttons = b;
    push(EV_LATCH, {7'd0, ~b[7]});
    latch = 1'b1;
    tick(hi);
    latch = 1'b0;
  endtask

  // One console clock pulse: low phase, rise, sample mid-high phase.
  task automatic rise_pulse(input int ph, input int pre, input logic exp);
    cclk = 1'b0;
    tick(ph);
    cclk = 1'b1;
    tick(pre);
    sample(exp);
    tick(ph - pre - 1);
  endtask

  // Host-side reader model: latch, read A, then seven clock pulses.
  task automatic host_read(input logic [7:0] b);
    logic [7:0] r;
    buttons = b;
    push(EV_LATCH, {7'd0, ~b[7]});
    push(EV_DONE,  {7'd0, ~b[0]});
    push(EV_HOST,  b);
    latch = 1'b1;
    tick(CPP);
    latch = 1'b0;
    tick(CPP / 2);
    r[7] = ~data;
    tick(CPP / 2);
    for (int i = 6; i >= 0; i--) begin
      cclk = 1'b0;
      tick(CPP);
      cclk = 1'b1;
      tick(CPP / 2);
      r[i] = ~data;
      tick(CPP / 2);
    end
    host_buttons = r;
    host_valid   = 1'b1;
    tick(1);
    host_valid   = 1'b0;
    tick(CPP);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    rst     = 1'b1;
    latch   = 1'b0;
    cclk    = 1'b1;
    buttons = 8'h00;
    tick(5);
    check("reset_data",      {7'd0, data},      8'd1);
    check("reset_latched",   {7'd0, latched},   8'd0);
    check("reset_read_done", {7'd0, read_done}, 8'd0);
    rst = 1'b0;
    tick(50);
    check("idle_data", {7'd0, data}, 8'd1);

    // Frame readout: A..Right = 0,1,0,1,1,1,1,0 on the wire.
    b = 8'b1010_0001;
    latch_frame(b, 20);
    tick(6);
    sample(~b[7]);
    tick(5);
    for (int i = 1; i <= 7; i++) begin
      if (i == 7) push(EV_DONE, {7'd0, ~b[0]});
      rise_pulse(12, 6, ~b[7-i]);
    end

    // Over-clocking: exhausted, data low, no second read_done.
    for (int i = 0; i < 3; i++) rise_pulse(12, 6, 1'b0);

    // Abort: three rises of 8'hFF, snapshot unaffected, then relatch 8'h00.
    latch_frame(8'hFF, 20);
    tick(6);
    sample(1'b0);
    tick(5);
    for (int i = 0; i < 3; i++) rise_pulse(12, 6, 1'b0);
    buttons = 8'h00;
    tick(6);
    sample(1'b0);
    latch = 1'b1;
    tick(3);
    sample(1'b0);
    sample(1'b1);
    tick(14);
    push(EV_LATCH, 8'd1);
    latch = 1'b0;
    tick(6);
    sample(1'b1);
    tick(5);
    for (int i = 1; i <= 7; i++) begin
      if (i == 7) push(EV_DONE, 8'd1);
      rise_pulse(12, 6, 1'b1);
    end

    // Loopback against the host reader.
    host_read(8'h5A);
    host_read(8'h00);
    host_read(8'hFF);
    host_read(8'h81);

    // Async reset after the third rise, then a clean frame.
    b = 8'h10;
    latch_frame(b, 20);
    tick(6);
    sample(~b[7]);
    tick(5);
    for (int i = 1; i <= 3; i++) rise_pulse(12, 6, ~b[7-i]);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_data",      {7'd0, data},      8'd1);
    check("async_rst_latched",   {7'd0, latched},   8'd0);
    check("async_rst_read_done", {7'd0, read_done}, 8'd0);
    tick(2);
    rst = 1'b0;
    tick(10);
    host_read(8'h3C);

    tick(20);
    n_checks++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: %0d events outstanding, expected 0", sb_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_nes_controller_device
`default_nettype wire

// File: doc/nes_controller_device.md
# nes_controller_device

Emulates the controller side of the NES serial pad protocol: samples the console's latch and clock lines, parallel-loads an 8-bit button word while latch is high, and shifts it out active-low on the data line, one bit per rising clock edge. Used to let the board act as a controller for a real console, or as a loopback target for the host-side controller reader in simulation and on hardware. Button word is supplied by fabric logic, for example switches or a UART bridge.

## Interface
- `SYNC_STAGES`, 2: flop depth of the latch and clock input synchronizers; must be ≥2.
- `clk`  in  1  system clock; the only clock.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_buttons`  in  8  button state, 1 = pressed; [7]=A, [6]=B, [5]=Select, [4]=Start, [3]=Up, [2]=Down, [1]=Left, [0]=Right.
- `i_console_latch`  in  1  latch line from console, asynchronous to `clk`, idles low.
- `i_console_clock`  in  1  clock line from console, asynchronous to `clk`, idles high.
- `o_console_data`  out  1  serial data to console, registered; low = pressed.
- `o_latched`  out  1  one-cycle pulse on synchronized latch falling edge, when the snapshot becomes final.
- `o_read_done`  out  1  one-cycle pulse when the eighth bit (Right) starts being driven.

## Operation
- Both inputs go through `SYNC_STAGES` flops. Edge detect uses one further flop per line.
- Synchronizer and edge flops reset to the idle levels: latch=0, clock=1. Reset therefore never produces a spurious edge.
- States:
  - IDLE: after reset; data=1 (released).
  - LOAD: synchronized latch high. The shift register reloads from `i_buttons` every cycle. Data = ~`i_buttons[7]`.
  - SHIFT: latch low. A 3-bit index counts bits presented. Each synchronized clock rising edge shifts left and drives the next bit.
  - EXHAUSTED: entered after 8 rising edges since latch fell. Data driven low, matching an official pad.
- Transitions:
  - Any state goes to LOAD while latch is high.
  - LOAD goes to SHIFT on latch fall; `o_latched` pulses and the index is 0.
  - SHIFT goes to EXHAUSTED on the rising edge taken at index 7.
  - EXHAUSTED holds until the next latch.
- Only rising edges of the clock line matter. Falling edges do nothing.
- In LOAD, clock edges are ignored (parallel load dominates).
- Latch high in SHIFT or EXHAUSTED aborts the frame. The word reloads and the index resets.
- `o_read_done` pulses exactly once per frame, on the edge that moves the index from 6 to 7.
  - Not asserted in a frame aborted earlier.
  - Not asserted on edges taken in EXHAUSTED.
- The snapshot is the `i_buttons` value present on the last LOAD cycle. Later changes have no effect until the next latch.

## Timing
- Reset values: `o_console_data`=1, `o_latched`=0, `o_read_done`=0, state IDLE, shift register 0, index 0.
- Async reset mid-frame forces `o_console_data` high immediately. No pulse is emitted.
- Latency from a pin transition to the `o_console_data` update is `SYNC_STAGES`+2 `clk` cycles (4 at default). This applies to both latch and clock edges.
- `o_latched` and `o_read_done` are asserted in the same cycle `o_console_data` updates.
- Console clock high and low phases must each exceed `SYNC_STAGES`+2 `clk` cycles. Shorter phases are outside the spec.
- Against the host-side reader, this requires the host's sample point (half a pulse after the rising clock edge) to exceed that latency in `clk` cycles.

## Structure
- Shared package `nes_pkg` holds:
  - the button bit indices (`BTN_A`=7 … `BTN_RIGHT`=0);
  - the device state encoding (IDLE, LOAD, SHIFT, EXHAUSTED);
  - the frame length constant `NES_BITS`=8.
- Sub-module `nes_sync` is a parameterized N-stage synchronizer with a reset-value parameter. It is instantiated twice: latch with reset value 0, clock with reset value 1.

## Test plan
- Reset: assert `i_rst` with inputs idle -> `o_console_data`=1, `o_latched`=0, `o_read_done`=0. No pulses appear for 50 cycles after release.
- Frame readout: set `i_buttons`=8'b1010_0001, latch for 20 cycles, then 7 clock pulses of 12/12 cycles.
  - Data sampled 6 cycles after each rise reads A..Right = 0,1,0,1,1,1,1,0.
  - `o_latched` pulses once; `o_read_done` pulses once, on the 7th rise.
- Over-clocking: continue with 3 more rising edges -> data stays 0 from the 8th edge on, with no second `o_read_done`.
- Abort: set `i_buttons`=8'hFF, latch, and give 3 rises. Change `i_buttons` to 8'h00 and latch again -> data returns to 1 (A released) 4 cycles after the latch rise, the index restarts, and there is no `o_read_done` for the aborted frame.
- Loopback: connect to the host-side reader with `CYCLES_PER_PULSE`=16. Issue a read with `i_buttons`=8'h5A -> host reports valid with buttons=8'h5A. Repeat for 8'h00, 8'hFF, and 8'h81.
- Async reset mid-frame: assert `i_rst` after the 3rd rise -> `o_console_data`=1 within the same cycle. The following frame reads correctly.
